// File: rtl/bcp_ctrl.sv
// Boolean constraint propagation sequencer.
// Starts each clause bank in turn, collects its done/imply/conflict response,
// and repeats full passes while any bank reports a new implication. A run ends
// on the first conflict, on a quiet pass, or when the repeat budget is used up.
// All outputs are registered: they are derived from the next-state values.
module bcp_ctrl #(
    parameter int NUM_BANK = 4,
    parameter int MAX_ITER = 15,
    parameter int BIDX_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_bcp,
    output logic [NUM_BANK-1:0] bank_start,
    input  logic [NUM_BANK-1:0] bank_done,
    input  logic [NUM_BANK-1:0] bank_imply,
    input  logic [NUM_BANK-1:0] bank_conflict,
    output logic                busy,
    output logic                done_bcp,
    output logic                conflict,
    output logic [BIDX_W-1:0]   conflict_bank,
    output logic [3:0]          iter_cnt,
    output logic                overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NUM_BANK - 1);
    localparam logic [3:0]        ITER_LIM = 4'(MAX_ITER);

    state_t              state_q, state_d;
    logic [BIDX_W-1:0]   idx_q, idx_d;
    logic                pass_imply_q, pass_imply_d;
    logic [NUM_BANK-1:0] bank_start_q, bank_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                conflict_q, conflict_d;
    logic [BIDX_W-1:0]   conflict_bank_q, conflict_bank_d;
    logic [3:0]          iter_q, iter_d;
    logic                overflow_q, overflow_d;

    // One-hot decodes of the current bank (for response selection) and of the
    // next bank (for the start strobe).
    logic [NUM_BANK-1:0] idx_oh_q;
    logic [NUM_BANK-1:0] idx_oh_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANK; gi++) begin : g_idx_dec
            assign idx_oh_q[gi] = (idx_q == BIDX_W'(gi));
            assign idx_oh_d[gi] = (idx_d == BIDX_W'(gi));
        end
    endgenerate

    // Only the bank currently being waited on is observed; other bits are masked.
    logic sel_done;
    logic sel_imply;
    logic sel_conflict;

    assign sel_done     = |(bank_done & idx_oh_q);
    assign sel_imply    = |(bank_imply & idx_oh_q);
    assign sel_conflict = |(bank_conflict & idx_oh_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pass_imply_d    = pass_imply_q;
        conflict_d      = conflict_q;
        conflict_bank_d = conflict_bank_q;
        iter_d          = iter_q;
        overflow_d      = overflow_q;

        case (state_q)
            IDLE: begin
                if (start_bcp) begin
                    state_d         = ISSUE;
                    idx_d           = '0;
                    pass_imply_d    = 1'b0;
                    conflict_d      = 1'b0;
                    conflict_bank_d = '0;
                    iter_d          = 4'd0;
                    overflow_d      = 1'b0;
                end
            end
            ISSUE: begin
                // The strobe is out this cycle; any done seen now is stale.
                state_d = WAIT;
            end
            WAIT: begin
                if (sel_done) begin
                    if (sel_conflict) begin
                        // Conflict wins over a simultaneous implication.
                        conflict_d      = 1'b1;
                        conflict_bank_d = idx_q;
                        state_d         = FINISH;
                    end else if (idx_q != LAST_IDX) begin
                        pass_imply_d = pass_imply_q | sel_imply;
                        idx_d        = idx_q + 1'b1;
                        state_d      = ISSUE;
                    end else if (!(pass_imply_q | sel_imply)) begin
                        state_d = FINISH;
                    end else if (iter_q < ITER_LIM) begin
                        iter_d       = iter_q + 4'd1;
                        idx_d        = '0;
                        pass_imply_d = 1'b0;
                        state_d      = ISSUE;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bank_start_d = (state_d == ISSUE) ? idx_oh_d : '0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            pass_imply_q    <= 1'b0;
            bank_start_q    <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            conflict_q      <= 1'b0;
            conflict_bank_q <= '0;
            iter_q          <= 4'd0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pass_imply_q    <= pass_imply_d;
            bank_start_q    <= bank_start_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            conflict_q      <= conflict_d;
            conflict_bank_q <= conflict_bank_d;
            iter_q          <= iter_d;
            overflow_q      <= overflow_d;
        end
    end

    assign bank_start    = bank_start_q;
    assign busy          = busy_q;
    assign done_bcp      = done_q;
    assign conflict      = conflict_q;
    assign conflict_bank = conflict_bank_q;
    assign iter_cnt      = iter_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/bcp_ctrl.md
BCP_CTRL -- requirements
Module: bcp_ctrl

Interface
REQ-001 Parameter NUM_BANK, default 4: number of clause banks sequenced; legal range 2..16.
REQ-002 Parameter MAX_ITER, default 15: maximum repeat passes after the first pass; legal range 1..15.
REQ-003 Parameter BIDX_W, default 2: width of the bank index; SHALL equal clog2(NUM_BANK).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start_bcp  input  1  request one propagation run; sampled only in IDLE.
REQ-007 bank_start  output  NUM_BANK  one-hot, single-cycle start strobe to one bank.
REQ-008 bank_done  input  NUM_BANK  per-bank evaluation-complete pulse.
REQ-009 bank_imply  input  NUM_BANK  per-bank new-implication flag; valid with bank_done.
REQ-010 bank_conflict  input  NUM_BANK  per-bank conflict flag; valid with bank_done.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done_bcp  output  1  single-cycle run-complete pulse.
REQ-013 conflict  output  1  run ended on a conflict; held until the next accepted start.
REQ-014 conflict_bank  output  BIDX_W  index of the conflicting bank; held until the next accepted start.
REQ-015 iter_cnt  output  4  number of repeat passes executed in the current or last run.
REQ-016 overflow  output  1  run ended because MAX_ITER was exhausted; held until the next accepted start.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and FINISH, with registered outputs.
REQ-018 IDLE with start_bcp=1 SHALL go to ISSUE, clear conflict, conflict_bank, overflow, iter_cnt, the bank index and pass_imply.
REQ-019 ISSUE SHALL assert bank_start[idx] for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL examine only bit idx of bank_done, bank_imply and bank_conflict; all other bits are ignored.
REQ-021 Any bank_done in an ISSUE cycle SHALL be ignored.
REQ-022 WAIT with bank_done[idx]=1 and bank_conflict[idx]=1 SHALL set conflict=1 and conflict_bank=idx, go to FINISH, and start no further banks.
REQ-023 Conflict SHALL take priority when bank_conflict[idx] and bank_imply[idx] are both 1.
REQ-024 WAIT with done, no conflict and idx<NUM_BANK-1 SHALL OR bank_imply[idx] into pass_imply, increment idx, and go to ISSUE.
REQ-025 At the end of a pass (done, no conflict, idx=NUM_BANK-1), with effective imply = pass_imply|bank_imply[idx], the FSM SHALL:
- effective imply=0: go to FINISH.
- effective imply=1 and iter_cnt<MAX_ITER: increment iter_cnt, set idx=0, clear pass_imply, go to ISSUE.
- effective imply=1 and iter_cnt=MAX_ITER: set overflow=1, go to FINISH.
REQ-026 FINISH SHALL assert done_bcp for exactly one cycle, then go to IDLE.
REQ-027 start_bcp while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-028 WAIT has no timeout; the FSM SHALL remain in WAIT until bank_done[idx] arrives or reset is applied.
REQ-029 Minimum cost SHALL be 2 cycles per bank; a no-implication run of NUM_BANK=4 SHALL pulse done_bcp in cycle 9 after the start edge.

Reset
REQ-030 While rst=1 the state SHALL be IDLE and every output SHALL be 0, including bank_start, busy, done_bcp, conflict, conflict_bank, iter_cnt and overflow.
REQ-031 Internal idx and pass_imply SHALL also reset to 0.
REQ-032 Reset mid-run SHALL abort with no done_bcp pulse.
REQ-033 A late bank_done after a mid-run reset SHALL be ignored.
REQ-034 The first start_bcp after rst falls SHALL be accepted normally.

Verification
REQ-035 Clean run (NUM_BANK=4, each bank returns done 1 cycle after its start, no imply or conflict) -> bank_start=0001, 0010, 0100, 1000 in cycles 1, 3, 5, 7; done_bcp in cycle 9; conflict=0, iter_cnt=0, overflow=0.
REQ-036 Single implication (bank 2 imply on pass 0 only) -> a second full pass runs; done_bcp in cycle 17; iter_cnt=1, conflict=0.
REQ-037 Conflict (bank 1 returns conflict=1 together with imply=1) -> done_bcp in cycle 5; conflict=1, conflict_bank=1; bank_start[2] and bank_start[3] never asserted.
REQ-038 Overflow (MAX_ITER=3, bank 0 imply on every pass) -> 4 passes; iter_cnt=3, overflow=1, conflict=0.
REQ-039 Reset abort (rst pulsed while in WAIT for bank 2, then bank_done[2] arrives) -> all outputs 0, no done_bcp; a fresh start then completes as in REQ-035.
REQ-040 Protocol noise (start_bcp held high during a run; bank_done[3] pulsed while waiting on bank 0; bank_done[0] asserted in its ISSUE cycle) -> all three ignored; exactly one run and one done_bcp result.
